// File: rtl/clock_reset_sequencer.sv
// clock_reset_sequencer
//
// Turns the three clock-manager lock indicators into staggered per-domain reset
// releases. The locks are synchronized, must stay all-high for LOCK_STABLE_CYCLES
// consecutive cycles, and then the SRAM, main and second-clock resets drop in that
// order, STAGE_GAP_CYCLES apart. system_ready follows one gap after the last release.
// Any lock drop after the first release re-asserts every reset, sets the sticky
// flags of the dropped locks and bumps a saturating loss counter.
//
// Ports:
//   input_clk        board clock (only clock)
//   reset            synchronous active-high reset, highest priority
//   dcm_locked       main DCM lock (asynchronous)
//   dcm_locked_two   second DCM lock (asynchronous)
//   dcm_locked_sram  SRAM clock lock (asynchronous)
//   clear_flags      one-cycle pulse, clears loss flags and loss counter
//   reset_sram       SRAM domain reset (active high)
//   reset_main       modified_clock domain reset (active high)
//   reset_two        modified_clock_two domain reset (active high)
//   system_ready     all domains released
//   lock_loss_flags  sticky loss flags {sram, two, main}
//   lock_loss_count  saturating loss-event count
//
// Build option: define LOCK_LOSS_COUNTER_EN to include the loss counter;
// otherwise lock_loss_count is tied to 0.

module clock_reset_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_GAP_CYCLES   = 16
) (
    input  logic       input_clk,
    input  logic       reset,
    input  logic       dcm_locked,
    input  logic       dcm_locked_two,
    input  logic       dcm_locked_sram,
    input  logic       clear_flags,
    output logic       reset_sram,
    output logic       reset_main,
    output logic       reset_two,
    output logic       system_ready,
    output logic [2:0] lock_loss_flags,
    output logic [7:0] lock_loss_count
);

    localparam int unsigned StableW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned GapW    = $clog2(STAGE_GAP_CYCLES + 1);

    // The WAIT_LOCK exit edge already counts as one all-locked sample, so the
    // stable counter only has to cover the remaining LOCK_STABLE_CYCLES-1 samples.
    localparam logic [StableW-1:0] StableLast = StableW'(LOCK_STABLE_CYCLES - 2);
    localparam logic [GapW-1:0]    GapLast    = GapW'(STAGE_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StWaitLock,
        StStable,
        StRelSram,
        StRelMain,
        StRelTwo,
        StRun
    } state_e;

    state_e             state_q, state_d;
    logic [StableW-1:0] stable_cnt_q, stable_cnt_d;
    logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [2:0]         lock_raw, sync1_q, sync2_q;
    logic               all_locked;
    logic               loss_event;
    logic [2:0]         dropped;
    logic [2:0]         flags_d;

    assign lock_raw   = {dcm_locked_sram, dcm_locked_two, dcm_locked};
    assign all_locked = &sync2_q;
    assign dropped    = ~sync2_q;

    // Two-flop synchronizers for the asynchronous lock inputs.
    always_ff @(posedge input_clk) begin
        if (reset) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= lock_raw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        loss_event   = 1'b0;
        unique case (state_q)
            StWaitLock: begin
                stable_cnt_d = '0;
                if (all_locked) state_d = StStable;
            end
            StStable: begin
                // A drop here only restarts stabilization; it is not a loss event.
                if (!all_locked) begin
                    state_d = StWaitLock;
                end else if (stable_cnt_q == StableLast) begin
                    state_d = StRelSram;
                end else begin
                    stable_cnt_d = stable_cnt_q + StableW'(1);
                end
            end
            StRelSram, StRelMain, StRelTwo: begin
                if (!all_locked) begin
                    state_d    = StWaitLock;
                    loss_event = 1'b1;
                end else if (gap_cnt_q == GapLast) begin
                    if (state_q == StRelSram) begin
                        state_d = StRelMain;
                    end else if (state_q == StRelMain) begin
                        state_d = StRelTwo;
                    end else begin
                        state_d = StRun;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            StRun: begin
                if (!all_locked) begin
                    state_d    = StWaitLock;
                    loss_event = 1'b1;
                end
            end
            default: state_d = StWaitLock;
        endcase
        if (state_d != state_q) begin
            stable_cnt_d = '0;
            gap_cnt_d    = '0;
        end
    end

    // A loss event wins over a coincident clear: flags become exactly the dropped bits.
    always_comb begin
        flags_d = lock_loss_flags;
        if (loss_event) begin
            flags_d = clear_flags ? dropped : (lock_loss_flags | dropped);
        end else if (clear_flags) begin
            flags_d = 3'b000;
        end
    end

    // Outputs are registered from the next state so they change on the same edge
    // as the state transition.
    always_ff @(posedge input_clk) begin
        if (reset) begin
            state_q         <= StWaitLock;
            stable_cnt_q    <= '0;
            gap_cnt_q       <= '0;
            reset_sram      <= 1'b1;
            reset_main      <= 1'b1;
            reset_two       <= 1'b1;
            system_ready    <= 1'b0;
            lock_loss_flags <= 3'b000;
        end else begin
            state_q         <= state_d;
            stable_cnt_q    <= stable_cnt_d;
            gap_cnt_q       <= gap_cnt_d;
            reset_sram      <= !(state_d inside {StRelSram, StRelMain, StRelTwo, StRun});
            reset_main      <= !(state_d inside {StRelMain, StRelTwo, StRun});
            reset_two       <= !(state_d inside {StRelTwo, StRun});
            system_ready    <= (state_d == StRun);
            lock_loss_flags <= flags_d;
        end
    end

`ifdef LOCK_LOSS_COUNTER_EN
    logic [7:0] count_q;

    always_ff @(posedge input_clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else if (loss_event) begin
            if (clear_flags) begin
                count_q <= 8'd1;
            end else if (count_q != 8'hFF) begin
                count_q <= count_q + 8'd1;
            end
        end else if (clear_flags) begin
            count_q <= 8'd0;
        end
    end

    assign lock_loss_count = count_q;
`else
    assign lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_clock_reset_sequencer.sv
module tb_clock_reset_sequencer;

    localparam int L = 8;
    localparam int G = 4;
`ifdef LOCK_LOSS_COUNTER_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic       input_clk = 1'b0;
    logic       reset = 1'b1;
    logic       l_main = 1'b0, l_two = 1'b0, l_sram = 1'b0;
    logic       clear_flags = 1'b0;
    logic       reset_sram, reset_main, reset_two, system_ready;
    logic [2:0] lock_loss_flags;
    logic [7:0] lock_loss_count;

    always #5 input_clk = ~input_clk;

    clock_reset_sequencer #(
        .LOCK_STABLE_CYCLES(L),
        .STAGE_GAP_CYCLES  (G)
    ) dut (
        .input_clk      (input_clk),
        .reset          (reset),
        .dcm_locked     (l_main),
        .dcm_locked_two (l_two),
        .dcm_locked_sram(l_sram),
        .clear_flags    (clear_flags),
        .reset_sram     (reset_sram),
        .reset_main     (reset_main),
        .reset_two      (reset_two),
        .system_ready   (system_ready),
        .lock_loss_flags(lock_loss_flags),
        .lock_loss_count(lock_loss_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: 'streak' is the number of consecutive edges at which the
    // sequencer has seen all locks high (the raw locks from two edges earlier).
    // Release milestones are thresholds on that streak.
    int         streak = 0;
    logic [2:0] hist0 = 3'b000, hist1 = 3'b000;
    logic [2:0] m_flags = 3'b000;
    int         m_count = 0;

    function automatic logic [3:0] outs();
        return {reset_sram, reset_main, reset_two, system_ready};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [2:0] locks, input logic clr);
        logic [2:0] seen;
        if (rst) begin
            hist0 = 3'b000; hist1 = 3'b000;
            streak = 0; m_flags = 3'b000; m_count = 0;
        end else begin
            seen = hist1;
            if (!(&seen) && streak >= L) begin
                if (clr) begin
                    m_flags = ~seen; m_count = 1;
                end else begin
                    m_flags = m_flags | ~seen;
                    if (m_count < 255) m_count++;
                end
            end else if (clr) begin
                m_flags = 3'b000; m_count = 0;
            end
            if (&seen) streak = (streak < 1000) ? streak + 1 : streak;
            else streak = 0;
            hist1 = hist0;
            hist0 = locks;
        end
    endtask

    // locks order is {sram, two, main}
    task automatic step(input logic rst, input logic [2:0] locks, input logic clr);
        logic [3:0] exp_o;
        logic [7:0] exp_c;
        reset = rst;
        {l_sram, l_two, l_main} = locks;
        clear_flags = clr;
        @(posedge input_clk);
        model_edge(rst, locks, clr);
        #1;
        exp_o = {streak < L, streak < L + G, streak < L + 2 * G, streak >= L + 3 * G};
        exp_c = CntEn ? 8'(m_count) : 8'd0;
        chk("model_outputs", {28'd0, outs()}, {28'd0, exp_o});
        chk("model_flags", {29'd0, lock_loss_flags}, {29'd0, m_flags});
        chk("model_count", {24'd0, lock_loss_count}, {24'd0, exp_c});
    endtask

    task automatic steps(input int n, input logic [2:0] locks);
        for (int i = 0; i < n; i++) step(1'b0, locks, 1'b0);
    endtask

    typedef struct {
        logic       rst;
        logic [2:0] locks;
        logic       clr;
        int         n;
        logic [3:0] exp_out;   // {reset_sram, reset_main, reset_two, system_ready}
        logic [2:0] exp_flags;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [2:0] d;
        logic [2:0] drop_union;

        // Release sequence; edge 0 is the first non-reset edge with all locks high.
        tbl[0] = '{1'b1, 3'b000, 1'b0, 2,  4'b1110, 3'b000};
        tbl[1] = '{1'b0, 3'b111, 1'b0, 9,  4'b1110, 3'b000};  // after edge 8
        tbl[2] = '{1'b0, 3'b111, 1'b0, 1,  4'b0110, 3'b000};  // edge 9
        tbl[3] = '{1'b0, 3'b111, 1'b0, 3,  4'b0110, 3'b000};  // edge 12
        tbl[4] = '{1'b0, 3'b111, 1'b0, 1,  4'b0010, 3'b000};  // edge 13
        tbl[5] = '{1'b0, 3'b111, 1'b0, 3,  4'b0010, 3'b000};  // edge 16
        tbl[6] = '{1'b0, 3'b111, 1'b0, 1,  4'b0000, 3'b000};  // edge 17
        tbl[7] = '{1'b0, 3'b111, 1'b0, 3,  4'b0000, 3'b000};  // edge 20
        tbl[8] = '{1'b0, 3'b111, 1'b0, 1,  4'b0001, 3'b000};  // edge 21
        tbl[9] = '{1'b0, 3'b111, 1'b0, 20, 4'b0001, 3'b000};

        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].rst, tbl[i].locks, tbl[i].clr);
            chk($sformatf("table_out_row%0d", i), {28'd0, outs()}, {28'd0, tbl[i].exp_out});
            chk($sformatf("table_flags_row%0d", i), {29'd0, lock_loss_flags},
                {29'd0, tbl[i].exp_flags});
            chk($sformatf("table_count_row%0d", i), {24'd0, lock_loss_count}, 32'd0);
        end

        // Lock drop in RUN: main and sram low at edge n.
        step(1'b0, 3'b010, 1'b0);
        step(1'b0, 3'b111, 1'b0);
        chk("drop_n1_outs", {28'd0, outs()}, {28'd0, 4'b0001});
        step(1'b0, 3'b111, 1'b0);
        chk("drop_n2_outs", {28'd0, outs()}, {28'd0, 4'b1110});
        chk("drop_n2_flags", {29'd0, lock_loss_flags}, {29'd0, 3'b101});
        chk("drop_n2_count", {24'd0, lock_loss_count}, CntEn ? 32'd1 : 32'd0);
        steps(7, 3'b111);
        chk("relock_n9_sram", {31'd0, reset_sram}, 32'd1);
        steps(1, 3'b111);
        chk("relock_n10_sram", {31'd0, reset_sram}, 32'd0);
        steps(11, 3'b111);
        chk("relock_n21_ready", {31'd0, system_ready}, 32'd0);
        steps(1, 3'b111);
        chk("relock_n22_ready", {31'd0, system_ready}, 32'd1);

        // One-cycle drop of dcm_locked_two at edge 5 during STABLE.
        step(1'b1, 3'b000, 1'b0);
        steps(5, 3'b111);
        step(1'b0, 3'b101, 1'b0);
        steps(9, 3'b111);
        chk("glitch_e14_sram", {31'd0, reset_sram}, 32'd1);
        steps(1, 3'b111);
        chk("glitch_e15_sram", {31'd0, reset_sram}, 32'd0);
        chk("glitch_flags", {29'd0, lock_loss_flags}, 32'd0);
        chk("glitch_count", {24'd0, lock_loss_count}, 32'd0);

        // 260 random drops in RUN, re-locking fully between each.
        step(1'b1, 3'b000, 1'b0);
        steps(24, 3'b111);
        drop_union = 3'b000;
        for (int i = 0; i < 260; i++) begin
            d = 3'($urandom_range(1, 7));
            drop_union = drop_union | d;
            step(1'b0, ~d, 1'b0);
            steps(24, 3'b111);
        end
        chk("sat_count", {24'd0, lock_loss_count}, CntEn ? 32'd255 : 32'd0);
        chk("sat_flags", {29'd0, lock_loss_flags}, {29'd0, drop_union});
        step(1'b0, 3'b111, 1'b1);
        chk("clear_count", {24'd0, lock_loss_count}, 32'd0);
        chk("clear_flags", {29'd0, lock_loss_flags}, 32'd0);
        step(1'b0, 3'b011, 1'b0);           // sram drop -> flags 100, count 1
        steps(24, 3'b111);
        step(1'b0, 3'b110, 1'b0);           // main drop, seen two edges later
        step(1'b0, 3'b111, 1'b0);
        step(1'b0, 3'b111, 1'b1);           // clear coincides with the loss event
        chk("coinc_flags", {29'd0, lock_loss_flags}, {29'd0, 3'b001});
        chk("coinc_count", {24'd0, lock_loss_count}, CntEn ? 32'd1 : 32'd0);

        // reset asserted in REL_MAIN.
        step(1'b1, 3'b000, 1'b0);
        steps(24, 3'b111);
        step(1'b0, 3'b000, 1'b0);
        steps(14, 3'b111);
        chk("relmain_outs", {28'd0, outs()}, {28'd0, 4'b0010});
        chk("relmain_flags", {29'd0, lock_loss_flags}, {29'd0, 3'b111});
        step(1'b1, 3'b111, 1'b0);
        chk("rst_mid_outs", {28'd0, outs()}, {28'd0, 4'b1110});
        chk("rst_mid_flags", {29'd0, lock_loss_flags}, 32'd0);
        chk("rst_mid_count", {24'd0, lock_loss_count}, 32'd0);
        steps(9, 3'b111);
        chk("restart_e8_sram", {31'd0, reset_sram}, 32'd1);
        steps(1, 3'b111);
        chk("restart_e9_sram", {31'd0, reset_sram}, 32'd0);

        // Randomized stimulus against the model.
        step(1'b1, 3'b000, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 599) == 0,
                 ($urandom_range(0, 29) == 0) ? 3'($urandom_range(0, 7)) : 3'b111,
                 $urandom_range(0, 59) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_reset_sequencer.md
# clock_reset_sequencer

Consumes the three lock indicators from the clock manager, `dcm_locked`, `dcm_locked_two` and `dcm_locked_sram`, and turns them into clean per-domain reset releases.
- Synchronizes the lock inputs.
- Requires a sustained all-locked interval before releasing anything.
- Releases the SRAM, main and second-clock domain resets in a fixed staggered order, then raises `system_ready`.
- Re-asserts every reset when any lock drops, and records which lock failed.

It runs on the board input clock and sits between the clock manager and all downstream reset trees.

## Interface
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronized all-locked cycles required before the first release. Must be at least 2.
- `STAGE_GAP_CYCLES`, default 16: cycles between successive releases, and between the last release and `system_ready`. Must be at least 1.

- `input_clk`  in  1  board clock. This is the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `dcm_locked`  in  1  main DCM lock. Asynchronous; synchronized internally.
- `dcm_locked_two`  in  1  second DCM lock. Asynchronous.
- `dcm_locked_sram`  in  1  SRAM clock lock. Asynchronous.
- `clear_flags`  in  1  single-cycle pulse; clears the loss flags and the loss counter.
- `reset_sram`  out  1  active-high reset for the SRAM domain.
- `reset_main`  out  1  active-high reset for the `modified_clock` domains.
- `reset_two`  out  1  active-high reset for the `modified_clock_two` domains.
- `system_ready`  out  1  high when all domains have been released.
- `lock_loss_flags`  out  3  sticky loss flags: bit 0 main, bit 1 two, bit 2 sram.
- `lock_loss_count`  out  8  saturating count of lock-loss events.

## Operation
**Synchronization**
- Each lock input passes through a 2-flop synchronizer, cleared to 0 by `reset`.
- `all_locked` is the AND of the three synchronized bits.

**States**
- WAIT_LOCK: all resets high, stable counter held at 0.
  - Leave for STABLE when `all_locked` is 1.
- STABLE: stable counter increments each cycle `all_locked` is 1.
  - If `all_locked` is 0, return to WAIT_LOCK and clear the counter.
  - When the counter reaches `LOCK_STABLE_CYCLES`, enter REL_SRAM.
- REL_SRAM: `reset_sram` goes to 0. After `STAGE_GAP_CYCLES`, enter REL_MAIN.
- REL_MAIN: `reset_main` goes to 0. After `STAGE_GAP_CYCLES`, enter REL_TWO.
- REL_TWO: `reset_two` goes to 0. After `STAGE_GAP_CYCLES`, enter RUN.
- RUN: `system_ready` goes to 1.

**Lock loss**
- Applies in any REL_* state or RUN when the FSM samples `all_locked` as 0.
- Next state is WAIT_LOCK; all three resets go to 1 and `system_ready` goes to 0 on that edge.
- A lock loss is one event:
  - Set the flag of every synchronized lock bit that is 0 at that sample.
  - Increment `lock_loss_count` by 1, saturating at 255.
  - Several bits dropping together still count as one event.
- A drop during STABLE only restarts stabilization. It is not a loss event.

**Flags and counter**
- `clear_flags` zeroes the flags and the counter on the next edge.
- If `clear_flags` coincides with a loss event, the event wins:
  - the flags become exactly the dropped bits;
  - the counter becomes 1.

**Widths**
- Stable counter: `$clog2(LOCK_STABLE_CYCLES+1)` bits.
- Gap counter: `$clog2(STAGE_GAP_CYCLES+1)` bits.
- Both counters are cleared on every state change.

**Reset**
- On `reset` at any edge, including mid-release:
  - `reset_sram`, `reset_main`, `reset_two` = 1;
  - `system_ready` = 0;
  - flags = 0, count = 0;
  - state WAIT_LOCK, synchronizers = 0.
- `reset` takes priority over every other input.

## Timing
**Release sequence** (edge 0 is the first edge that samples all raw locks high and they stay high)
- The synchronized value is visible after edge 1; the FSM first acts at edge 2.
- `reset_sram` falls after edge `LOCK_STABLE_CYCLES+1`.
- `reset_main` falls `STAGE_GAP_CYCLES` later.
- `reset_two` falls another `STAGE_GAP_CYCLES` later.
- `system_ready` rises another `STAGE_GAP_CYCLES` later.

**Lock drop**
- A raw drop is sampled at edge n.
- Resets are high and `system_ready` is low after edge n+2.
- Flags and count are updated after the same edge.

**Glitches**
- A synchronized low of one cycle triggers the full response; there is no glitch filter.

**Outputs**
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- `LOCK_LOSS_COUNTER_EN`
  - Defined: `lock_loss_count` is the 8-bit saturating counter described above.
  - Undefined: no counter register; `lock_loss_count` is tied to 0.
- `lock_loss_flags` behaves the same in both builds.

## Test plan
All scenarios use `LOCK_STABLE_CYCLES`=8 and `STAGE_GAP_CYCLES`=4.
- Reset, then all locks high from edge 0 → `reset_sram` low after edge 9, `reset_main` low after edge 13, `reset_two` low after edge 17, `system_ready` high after edge 21.
- `dcm_locked_two` low for one cycle at edge 5 during STABLE → stabilization restarts, `reset_sram` falls 8 cycles after the lock re-rises plus 1; flags 0, count 0.
- In RUN, `dcm_locked` and `dcm_locked_sram` drop at edge 100 → all resets high and ready low after edge 102; flags = 3'b101, count = 1; re-lock repeats the full sequence.
- 260 single-cycle drops in RUN, with re-lock between each → count saturates at 255; a `clear_flags` pulse gives 0; a pulse coinciding with a loss gives count 1 and only the dropped flag set.
- `reset` asserted in REL_MAIN (`reset_sram` already low) → after that edge all resets are 1, ready is 0, flags and count are 0; the sequence restarts from WAIT_LOCK.
- Build without `LOCK_LOSS_COUNTER_EN`, repeat the RUN drop scenario → `lock_loss_count` stays 0 and the flags match the counter-enabled build.
